// File: rtl/mem_copy_ctrl.sv
// Purpose: memcpy sequencer and host-port arbiter for a single-port sync-read RAM.
// Latency: 2 cycles per byte (RD then WR); done pulses in cycle 2*num+1 after the start edge.
// Backpressure: start is ignored while busy; host_req stalls (host_gnt=0) outside IDLE or when start is high.
//
// Ports:
//   clk, rst                    clock; asynchronous active-high reset
//   start, src, dst, num        job request and its parameters (captured in IDLE)
//   busy, done                  engine active / one-cycle end-of-job pulse
//   host_req/we/addr/wdata      host access request, held until host_gnt
//   host_gnt, host_rdata        combinational grant; read data (= ram_q)
//   host_rvalid                 high the cycle after a granted host read
//   ram_addr/wdata/we/re, ram_q RAM control pins and registered read data
//
// Build option: define MEM_COPY_MEMMOVE_EN to copy backwards when dst overlaps
// the source window above src, giving snapshot (memmove) semantics.
module mem_copy_ctrl #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] src,
    input  logic [AW-1:0] dst,
    input  logic [AW-1:0] num,
    output logic          busy,
    output logic          done,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_gnt,
    output logic [DW-1:0] host_rdata,
    output logic          host_rvalid,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_we,
    output logic          ram_re,
    input  logic [DW-1:0] ram_q
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [AW-1:0] ONE = 1;

    logic [1:0]    state;
    logic [AW-1:0] src_ptr;
    logic [AW-1:0] dst_ptr;
    logic [AW-1:0] count;
    logic          dir_down;
    logic          job_accept;

    assign job_accept = (state == S_IDLE) && start;

`ifdef MEM_COPY_MEMMOVE_EN
    // Overlap test is done on AW+1 bits so a source window that runs past
    // the top of memory still compares correctly against dst.
    logic [AW:0] src_end;
    logic        overlap;

    assign src_end = {1'b0, src} + {1'b0, num};
    assign overlap = (dst > src) && ({1'b0, dst} < src_end);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir_down <= 1'b0;
        end else if (job_accept) begin
            dir_down <= overlap;
        end
    end
`else
    assign dir_down = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            src_ptr     <= '0;
            dst_ptr     <= '0;
            count       <= '0;
            host_rvalid <= 1'b0;
        end else begin
            // The RAM returns read data one cycle after ram_re.
            host_rvalid <= host_gnt & ~host_we;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        count <= num;
`ifdef MEM_COPY_MEMMOVE_EN
                        if (overlap) begin
                            src_ptr <= src + num - ONE;
                            dst_ptr <= dst + num - ONE;
                        end else begin
                            src_ptr <= src;
                            dst_ptr <= dst;
                        end
`else
                        src_ptr <= src;
                        dst_ptr <= dst;
`endif
                        state <= (num == '0) ? S_DONE : S_RD;
                    end
                end
                S_RD: begin
                    state <= S_WR;
                end
                S_WR: begin
                    // Pointers wrap naturally mod 2**AW.
                    src_ptr <= dir_down ? (src_ptr - ONE) : (src_ptr + ONE);
                    dst_ptr <= dir_down ? (dst_ptr - ONE) : (dst_ptr + ONE);
                    count   <= count - ONE;
                    state   <= (count == ONE) ? S_DONE : S_RD;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Engine wins a tie with the host; reset also blocks the grant so the
    // RAM pins sit idle for as long as rst is held.
    assign host_gnt   = host_req && (state == S_IDLE) && !start && !rst;
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);
    assign host_rdata = ram_q;

    always_comb begin
        ram_addr  = '0;
        ram_wdata = '0;
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        case (state)
            S_IDLE: begin
                if (host_gnt) begin
                    ram_addr  = host_addr;
                    ram_wdata = host_wdata;
                    ram_we    = host_we;
                    ram_re    = ~host_we;
                end
            end
            S_RD: begin
                ram_addr = src_ptr;
                ram_re   = 1'b1;
            end
            S_WR: begin
                // Byte read in the previous RD cycle goes straight back out.
                ram_addr  = dst_ptr;
                ram_wdata = ram_q;
                ram_we    = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mem_copy_ctrl.sv
// Purpose: self-checking bench for mem_copy_ctrl with a behavioural sync-read RAM.
// Latency: host reads checked one cycle after grant; job timing checked per cycle.
// Backpressure: host requests are held until granted, bounded by a cycle budget.
module tb_mem_copy_ctrl;

    localparam int AW = 8;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] src = '0;
    logic [AW-1:0] dst = '0;
    logic [AW-1:0] num = '0;
    logic          busy;
    logic          done;
    logic          host_req = 1'b0;
    logic          host_we = 1'b0;
    logic [AW-1:0] host_addr = '0;
    logic [DW-1:0] host_wdata = '0;
    logic          host_gnt;
    logic [DW-1:0] host_rdata;
    logic          host_rvalid;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_we;
    logic          ram_re;
    logic [DW-1:0] ram_q;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] mem [256];
    logic [DW-1:0] sh  [256];
    logic [DW-1:0] exp_q [$];

    always #5 clk = ~clk;

    mem_copy_ctrl #(.AW(AW), .DW(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .src         (src),
        .dst         (dst),
        .num         (num),
        .busy        (busy),
        .done        (done),
        .host_req    (host_req),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_gnt    (host_gnt),
        .host_rdata  (host_rdata),
        .host_rvalid (host_rvalid),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_we      (ram_we),
        .ram_re      (ram_re),
        .ram_q       (ram_q)
    );

    // Behavioural single-port RAM with registered read data.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        if (ram_re) ram_q <= mem[ram_addr];
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard consumer: every host read response is compared in order.
    always @(negedge clk) begin
        if (host_rvalid) begin
            if (exp_q.size() == 0) begin
                check_val("rvalid_unexpected", 1, 0);
            end else begin
                check_val("host_rdata", host_rdata, exp_q.pop_front());
            end
        end
    end

    // Reference copy on the shadow memory.
    task automatic model_copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] n);
`ifdef MEM_COPY_MEMMOVE_EN
        logic [DW-1:0] snap [256];
        snap = sh;
        for (int i = 0; i < int'(n); i++) sh[8'(int'(d) + i)] = snap[8'(int'(s) + i)];
`else
        for (int i = 0; i < int'(n); i++) sh[8'(int'(d) + i)] = sh[8'(int'(s) + i)];
`endif
    endtask

    task automatic host_acc(input logic we, input logic [7:0] a, input logic [7:0] wd);
        bit g;
        g = 1'b0;
        @(negedge clk);
        host_req = 1'b1; host_we = we; host_addr = a; host_wdata = wd;
        for (int i = 0; i < 50 && !g; i++) begin
            #1;
            if (host_gnt) g = 1'b1;
            else @(negedge clk);
        end
        if (!g) begin
            check_val("host_gnt_timeout", 0, 1);
            host_req = 1'b0;
        end else begin
            if (we) sh[a] = wd;
            else exp_q.push_back(sh[a]);
            @(posedge clk);
            #1 host_req = 1'b0;
            if (!we) begin
                @(negedge clk);
                check_val("host_rvalid_after_gnt", host_rvalid, 1);
            end
        end
    endtask

    task automatic check_region(input logic [7:0] a, input int len);
        for (int i = 0; i < len; i++) host_acc(1'b0, 8'(int'(a) + i), 8'h00);
    endtask

    task automatic run_job(input logic [7:0] s, input logic [7:0] d, input logic [7:0] n,
                           input bit with_host, input logic [7:0] ha, input string tag);
        int done_at, busy_cnt, we_cnt, re_cnt, gnt_busy;
        done_at = 0; busy_cnt = 0; we_cnt = 0; re_cnt = 0; gnt_busy = 0;
        @(negedge clk);
        start = 1'b1; src = s; dst = d; num = n;
        if (with_host) begin
            host_req = 1'b1; host_we = 1'b0; host_addr = ha;
            #1 check_val({tag, "_tie_gnt"}, host_gnt, 0);
        end
        @(posedge clk);
        model_copy(s, d, n);
        #1 start = 1'b0;
        for (int c = 1; c <= 600 && done_at == 0; c++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (ram_we) we_cnt++;
            if (ram_re) re_cnt++;
            if (host_gnt) gnt_busy++;
            if (done) done_at = c;
        end
        check_val({tag, "_done_cycle"}, done_at, 2 * int'(n) + 1);
        check_val({tag, "_busy_cycles"}, busy_cnt, 2 * int'(n) + 1);
        check_val({tag, "_we_count"}, we_cnt, int'(n));
        check_val({tag, "_re_count"}, re_cnt, int'(n));
        @(negedge clk);
        check_val({tag, "_done_pulse_end"}, done, 0);
        if (with_host) begin
            check_val({tag, "_gnt_while_busy"}, gnt_busy, 0);
            check_val({tag, "_gnt_after_done"}, host_gnt, 1);
            if (host_gnt) begin
                exp_q.push_back(sh[ha]);
                @(posedge clk);
                #1 host_req = 1'b0;
                @(negedge clk);
                check_val({tag, "_rvalid"}, host_rvalid, 1);
            end else begin
                host_req = 1'b0;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int we_cnt;
        bit saw_done;
        for (int i = 0; i < 256; i++) begin
            mem[i] = '0;
            sh[i]  = '0;
        end
        ram_q = '0;

        // Reset state
        @(negedge clk);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_rvalid", host_rvalid, 0);
        check_val("rst_ram_we", ram_we, 0);
        check_val("rst_ram_re", ram_re, 0);
        check_val("rst_ram_addr", ram_addr, 0);
        check_val("rst_host_gnt", host_gnt, 0);
        rst = 1'b0;

        // 1: plain copy
        for (int i = 0; i < 5; i++) host_acc(1'b1, 8'(4 + i), 8'(8'hA1 + i));
        run_job(8'd4, 8'd16, 8'd5, 1'b0, 8'd0, "t1");
        check_region(8'd16, 5);

        // 2: overlapping copy with dst above src
        run_job(8'd4, 8'd7, 8'd5, 1'b0, 8'd0, "t2");
        check_region(8'd7, 5);

        // 3: zero-length job
        run_job(8'd0, 8'd0, 8'd0, 1'b0, 8'd0, "t3");

        // 4: source window wrapping past the top of memory
        host_acc(1'b1, 8'd254, 8'hB0);
        host_acc(1'b1, 8'd255, 8'hB1);
        host_acc(1'b1, 8'd0,   8'hB2);
        host_acc(1'b1, 8'd1,   8'hB3);
        run_job(8'd254, 8'd32, 8'd4, 1'b0, 8'd0, "t4");
        check_region(8'd32, 4);

        // 5: host request tied with start and held through the job
        run_job(8'd16, 8'd64, 8'd3, 1'b1, 8'd65, "t5");
        check_region(8'd64, 3);

        // 6: reset in the middle of a job
        for (int i = 0; i < 5; i++) host_acc(1'b1, 8'(4 + i), 8'(8'hA1 + i));
        for (int i = 0; i < 5; i++) host_acc(1'b1, 8'(40 + i), 8'(8'h50 + i));
        @(negedge clk);
        start = 1'b1; src = 8'd4; dst = 8'd40; num = 8'd5;
        @(posedge clk);
        #1 start = 1'b0;
        we_cnt = 0;
        for (int c = 0; c < 20 && we_cnt < 2; c++) begin
            @(negedge clk);
            if (ram_we) we_cnt++;
        end
        check_val("t6_two_writes_seen", we_cnt, 2);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("t6_rst_busy", busy, 0);
        check_val("t6_rst_done", done, 0);
        check_val("t6_rst_ram_we", ram_we, 0);
        check_val("t6_rst_ram_re", ram_re, 0);
        check_val("t6_rst_rvalid", host_rvalid, 0);
        sh[40] = sh[4];
        sh[41] = sh[5];
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        check_val("t6_no_done", saw_done, 0);
        check_region(8'd40, 5);
        run_job(8'd4, 8'd40, 8'd5, 1'b0, 8'd0, "t6_after");
        check_region(8'd40, 5);

        repeat (3) @(negedge clk);
        check_val("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
